// File: rtl/dmem_bridge.sv
// dmem_bridge
//   Bridges the core's load/store port to a word-wide RAM / peripheral bus.
//   A byte-addressed RISC-V access (op = funct3 style size/sign code) is
//   turned into a word-aligned bus request with byte enables and
//   lane-replicated store data. The bus handshake tolerates wait states,
//   and load data comes back sign- or zero-extended. Misaligned accesses,
//   illegal op codes and bus timeouts all end in a one-cycle error pulse.
//
// Parameters
//   TIMEOUT  max WAIT cycles without mem_ack before aborting (>= 1)
//   TO_W     timeout counter width, 2**TO_W > TIMEOUT
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   cpu_req/we/addr/op/wdata   core request (sampled in IDLE only)
//   cpu_rdata             extended load data, meaningful while cpu_done=1
//   cpu_busy              stall to the core
//   cpu_done / cpu_err    one-cycle completion / error pulses
//   mem_req/we/addr/be/wdata   bus request side
//   mem_rdata, mem_ack    bus response (data valid with ack)
module dmem_bridge #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [2:0]  cpu_op,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  state_t          state_reg, state_next;
  logic            we_reg;
  logic [31:0]     addr_reg;
  logic [2:0]      op_reg;
  logic [31:0]     wdata_reg;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next, to_cnt_inc;
  logic [31:0]     rdata_reg, rdata_next;
  logic            capture;
  logic            req_bad;
  logic [3:0]      be_lanes;
  logic [31:0]     wdata_lanes;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_value;

  // Reject illegal op codes and accesses that straddle their natural size.
  always_comb begin
    req_bad = 1'b0;
    case (cpu_op)
      3'b000, 3'b100: req_bad = 1'b0;
      3'b001, 3'b101: req_bad = cpu_addr[0];
      3'b010:         req_bad = (cpu_addr[1:0] != 2'b00);
      default:        req_bad = 1'b1;
    endcase
  end

  // Byte enables and store-data replication from the latched request.
  always_comb begin
    be_lanes    = 4'b1111;
    wdata_lanes = wdata_reg;
    case (op_reg[1:0])
      2'b00: begin
        be_lanes    = 4'b0001 << addr_reg[1:0];
        wdata_lanes = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        be_lanes    = 4'b0011 << addr_reg[1:0];
        wdata_lanes = {2{wdata_reg[15:0]}};
      end
      default: begin
        be_lanes    = 4'b1111;
        wdata_lanes = wdata_reg;
      end
    endcase
  end

  // Lane select and extension of the returned bus word.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (addr_reg[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_reg)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_value = {24'h000000, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_value = {16'h0000, ld_half};
      default: ld_value = mem_rdata;
    endcase
  end

  assign to_cnt_inc = to_cnt_reg + 1'b1;

  always_comb begin
    state_next  = state_reg;
    to_cnt_next = to_cnt_reg;
    rdata_next  = rdata_reg;
    capture     = 1'b0;
    case (state_reg)
      IDLE: begin
        to_cnt_next = '0;
        if (cpu_req) begin
          capture    = 1'b1;
          state_next = req_bad ? ERR : WAIT;
        end
      end
      WAIT: begin
        // to_cnt_inc is the 1-based index of the current WAIT cycle; an ack
        // in the final allowed cycle still completes normally.
        if (mem_ack) begin
          if (!we_reg) rdata_next = ld_value;
          to_cnt_next = '0;
          state_next  = DONE;
        end else if (to_cnt_inc == TO_LIMIT) begin
          to_cnt_next = '0;
          state_next  = ERR;
        end else begin
          to_cnt_next = to_cnt_inc;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      op_reg     <= '0;
      wdata_reg  <= '0;
      to_cnt_reg <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      to_cnt_reg <= to_cnt_next;
      rdata_reg  <= rdata_next;
      if (capture) begin
        we_reg    <= cpu_we;
        addr_reg  <= cpu_addr;
        op_reg    <= cpu_op;
        wdata_reg <= cpu_wdata;
      end
    end
  end

  // The request-cycle stall is combinational so the core freezes at once.
  assign cpu_busy  = (state_reg == WAIT) || ((state_reg == IDLE) && cpu_req && !rst);
  assign cpu_done  = (state_reg == DONE);
  assign cpu_err   = (state_reg == ERR);
  assign cpu_rdata = cpu_err ? 32'h0 : rdata_reg;

  assign mem_req   = (state_reg == WAIT);
  assign mem_we    = mem_req && we_reg;
  assign mem_addr  = {addr_reg[31:2], 2'b00};
  assign mem_be    = mem_req ? be_lanes : 4'b0000;
  assign mem_wdata = mem_req ? wdata_lanes : 32'h0;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge
//   Directed bench for dmem_bridge with TIMEOUT=4. Each transfer prints one
//   line; every comparison goes through check().
module tb_dmem_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [2:0]  cpu_op;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_total = 0;
  int n_pass  = 0;

  dmem_bridge #(.TIMEOUT(4), .TO_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_op    (cpu_op),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_busy  (cpu_busy),
    .cpu_done  (cpu_done),
    .cpu_err   (cpu_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One complete transfer. ack_at = WAIT cycle (1-based) in which mem_ack is
  // raised, 0 = never. exp_ok=1 expects cpu_done, 0 expects cpu_err.
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [2:0] op, input logic [31:0] wd, input logic [31:0] rd,
                      input int ack_at, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input logic exp_ok, input logic [31:0] exp_rdata,
                      input int exp_lat, input int exp_reqs);
    int  lat;
    int  reqs;
    bit  fin;
    lat  = 0;
    reqs = 0;
    fin  = 0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_op    = op;
    cpu_wdata = wd;
    mem_rdata = rd;
    mem_ack   = 1'b0;
    #1;
    check({tag, " busy_req"}, 32'(cpu_busy), 32'd1);
    check({tag, " memreq_req"}, 32'(mem_req), 32'd0);
    while (!fin && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (cpu_done || cpu_err) begin
        fin = 1;
        mem_ack = 1'b0;
      end else if (mem_req) begin
        reqs++;
        if (reqs == 1) begin
          check({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
          check({tag, " be"}, 32'(mem_be), 32'(exp_be));
          check({tag, " wdata"}, mem_wdata, exp_wd);
          check({tag, " we"}, 32'(mem_we), 32'(we));
          check({tag, " busy_wait"}, 32'(cpu_busy), 32'd1);
        end
        mem_ack = (reqs == ack_at);
      end
    end
    check({tag, " done"}, 32'(cpu_done), 32'(exp_ok));
    check({tag, " err"}, 32'(cpu_err), 32'(!exp_ok));
    check({tag, " rdata"}, cpu_rdata, exp_rdata);
    check({tag, " busy_end"}, 32'(cpu_busy), 32'd0);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " req_cycles"}, 32'(reqs), 32'(exp_reqs));
    $display("xfer %s we=%0d addr=%08h op=%0d -> done=%0d err=%0d rdata=%08h lat=%0d reqs=%0d",
             tag, we, addr, op, cpu_done, cpu_err, cpu_rdata, lat, reqs);
    // cpu_req was still high in the completion cycle; it must not have started
    // a new access.
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " idle_done"}, 32'(cpu_done), 32'd0);
    check({tag, " idle_err"}, 32'(cpu_err), 32'd0);
    check({tag, " idle_req"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_op    = 3'b000;
    cpu_wdata = 32'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(cpu_busy), 32'd0);
    check("rst done", 32'(cpu_done), 32'd0);
    check("rst err", 32'(cpu_err), 32'd0);
    check("rst rdata", cpu_rdata, 32'h0);
    check("rst memreq", 32'(mem_req), 32'd0);
    check("rst memwe", 32'(mem_we), 32'd0);
    check("rst addr", mem_addr, 32'h0);
    check("rst be", 32'(mem_be), 32'h0);
    check("rst wdata", mem_wdata, 32'h0);
    $display("reset state checked");
    rst = 1'b0;
    @(posedge clk);
    #1;

    //    tag     we    addr          op      wdata         mem_rdata     ack be       exp_wd        ok exp_rdata    lat reqs
    xfer("SW",   1'b1, 32'h0000_0104, 3'b010, 32'hDEAD_BEEF, 32'h0,        1, 4'b1111, 32'hDEAD_BEEF, 1, 32'h0,        2, 1);
    xfer("SB",   1'b1, 32'h0000_0203, 3'b000, 32'h0000_00A5, 32'h0,        1, 4'b1000, 32'hA5A5_A5A5, 1, 32'h0,        2, 1);
    xfer("LB",   1'b0, 32'h0000_0302, 3'b000, 32'h0,         32'h1280_FF34, 1, 4'b0100, 32'h0,        1, 32'hFFFF_FF80, 2, 1);
    xfer("LBU",  1'b0, 32'h0000_0302, 3'b100, 32'h0,         32'h1280_FF34, 1, 4'b0100, 32'h0,        1, 32'h0000_0080, 2, 1);
    xfer("LH",   1'b0, 32'h0000_0302, 3'b001, 32'h0,         32'h1280_FF34, 1, 4'b1100, 32'h0,        1, 32'h0000_1280, 2, 1);
    xfer("SH",   1'b1, 32'h0000_0102, 3'b001, 32'h1234_BEEF, 32'h0,        3, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0000_1280, 4, 3);
    xfer("LHlo", 1'b0, 32'h0000_0500, 3'b001, 32'h0,         32'h7FFF_8001, 2, 4'b0011, 32'h0,        1, 32'hFFFF_8001, 3, 2);
    xfer("LHU",  1'b0, 32'h0000_0502, 3'b101, 32'h0,         32'h8001_7FFF, 1, 4'b1100, 32'h0,        1, 32'h0000_8001, 2, 1);
    xfer("LBb1", 1'b0, 32'h0000_0501, 3'b000, 32'h0,         32'h0000_7F00, 1, 4'b0010, 32'h0,        1, 32'h0000_007F, 2, 1);
    xfer("LWmis",1'b0, 32'h0000_0401, 3'b010, 32'h0,         32'h0,        1, 4'b0000, 32'h0,        0, 32'h0,        1, 0);
    xfer("OP011",1'b0, 32'h0000_0400, 3'b011, 32'h0,         32'h0,        1, 4'b0000, 32'h0,        0, 32'h0,        1, 0);
    xfer("LHmis",1'b0, 32'h0000_0303, 3'b101, 32'h0,         32'h0,        1, 4'b0000, 32'h0,        0, 32'h0,        1, 0);
    xfer("LWto", 1'b0, 32'h0000_0500, 3'b010, 32'h0,         32'h0,        0, 4'b1111, 32'h0,        0, 32'h0,        5, 4);
    xfer("LWack4",1'b0,32'h0000_0500, 3'b010, 32'h0,         32'hCAFE_F00D, 4, 4'b1111, 32'h0,        1, 32'hCAFE_F00D, 5, 4);

    // Reset while the bus is stalled in the second WAIT cycle.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0600;
    cpu_op   = 3'b010;
    mem_ack  = 1'b0;
    @(posedge clk); #1;
    check("RST wait1 memreq", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    check("RST wait2 memreq", 32'(mem_req), 32'd1);
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("RST memreq", 32'(mem_req), 32'd0);
    check("RST busy", 32'(cpu_busy), 32'd0);
    check("RST done", 32'(cpu_done), 32'd0);
    check("RST err", 32'(cpu_err), 32'd0);
    check("RST addr", mem_addr, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("RST quiet done", 32'(cpu_done), 32'd0);
      check("RST quiet err", 32'(cpu_err), 32'd0);
      check("RST quiet memreq", 32'(mem_req), 32'd0);
    end
    $display("xfer RST mid-WAIT -> mem_req=%0d busy=%0d done=%0d err=%0d", mem_req, cpu_busy, cpu_done, cpu_err);
    xfer("SWpost",1'b1,32'h0000_0104, 3'b010, 32'h0BAD_F00D, 32'h0,        1, 4'b1111, 32'h0BAD_F00D, 1, 32'h0,        2, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
